// File: rtl/heli_motion.sv
// rtl/heli_motion.sv - helicopter vertical motion controller (optional HELI_MANUAL_MODE_EN)
module heli_motion #(
  parameter int POS_W     = 7,
  parameter int VEL_W     = 5,
  parameter int START_POS = 60,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 119,
  parameter int THRUST    = 2,
  parameter int GRAV_DIV  = 2,
  parameter int VEL_MAX   = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             start,
  input  logic             thrust,
  input  logic             collide,
`ifdef HELI_MANUAL_MODE_EN
  input  logic             down,
  input  logic             manual,
`endif
  output logic [POS_W-1:0] pos,
  output logic [VEL_W-1:0] vel,
  output logic [1:0]       state,
  output logic             crashed,
  output logic             hit_top
);

  // Two guard bits on position and velocity sums so overshoot never wraps.
  localparam int PW     = POS_W + 2;
  localparam int VS_W   = VEL_W + 2;
  localparam int GCNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FLY   = 2'b01;
  localparam logic [1:0] S_CRASH = 2'b10;

  localparam logic signed [VS_W-1:0]  THR_S   = VS_W'(THRUST);
  localparam logic signed [VS_W-1:0]  ONE_S   = VS_W'(1);
  localparam logic signed [VS_W-1:0]  VMAX_S  = VS_W'(VEL_MAX);
  localparam logic signed [VS_W-1:0]  VMIN_S  = -VMAX_S;
  localparam logic signed [VEL_W-1:0] VMAX_V  = VEL_W'(VEL_MAX);
  localparam logic signed [VEL_W-1:0] VMIN_V  = -VMAX_V;
  localparam logic signed [PW-1:0]    PMAX_S  = PW'(POS_MAX);
  localparam logic signed [PW-1:0]    PMIN_S  = PW'(POS_MIN);
  localparam logic [POS_W-1:0]        PMAX_U  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]        PMIN_U  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]        PSTART  = POS_W'(START_POS);
  localparam logic [GCNT_W-1:0]       GLAST   = GCNT_W'(GRAV_DIV - 1);

  logic [1:0]              state_q, state_d;
  logic [POS_W-1:0]        pos_q;
  logic signed [VEL_W-1:0] vel_q;
  logic [GCNT_W-1:0]       gcnt_q;
  logic                    hit_top_q;

  logic                    man_on;
  logic                    grav;
  logic signed [VS_W-1:0]  thr_add, grav_sub, v_sum;
  logic signed [VEL_W-1:0] v_new;
  logic signed [PW-1:0]    p_sum;
  logic                    at_top, at_floor;
  logic [POS_W-1:0]        p_man;

`ifdef HELI_MANUAL_MODE_EN
  assign man_on = manual;
`else
  assign man_on = 1'b0;
`endif

  // Physics candidate for the current tick: velocity with thrust/gravity, saturated, then position.
  always_comb begin
    grav     = (gcnt_q == GLAST);
    thr_add  = thrust ? THR_S : '0;
    grav_sub = grav ? ONE_S : '0;
    v_sum    = VS_W'(vel_q) + thr_add - grav_sub;
    if (v_sum > VMAX_S) begin
      v_new = VMAX_V;
    end else if (v_sum < VMIN_S) begin
      v_new = VMIN_V;
    end else begin
      v_new = v_sum[VEL_W-1:0];
    end
    p_sum    = $signed({2'b00, pos_q}) + PW'(v_new);
    at_top   = (p_sum >= PMAX_S);
    at_floor = (p_sum <= PMIN_S) && !at_top;
    p_man    = pos_q;
`ifdef HELI_MANUAL_MODE_EN
    if (thrust) begin
      if (pos_q < PMAX_U) p_man = pos_q + 1'b1;
    end else if (down) begin
      if (pos_q > PMIN_U) p_man = pos_q - 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: crash on collide or floor contact, start toggles IDLE/FLY and CRASH/IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FLY;
      S_FLY:   if (!man_on && (collide || (tick && at_floor))) state_d = S_CRASH;
      S_CRASH: if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: position, velocity, gravity counter and the one-clk ceiling pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_q     <= PSTART;
      vel_q     <= '0;
      gcnt_q    <= '0;
      hit_top_q <= 1'b0;
    end else begin
      hit_top_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pos_q  <= PSTART;
          vel_q  <= '0;
          gcnt_q <= '0;
        end
        S_FLY: begin
          if (tick) begin
            if (man_on) begin
              pos_q <= p_man;
              vel_q <= '0;
            end else begin
              gcnt_q <= grav ? '0 : gcnt_q + 1'b1;
              if (at_top) begin
                pos_q     <= PMAX_U;
                vel_q     <= '0;
                hit_top_q <= !collide;
              end else if (at_floor) begin
                pos_q <= PMIN_U;
                vel_q <= '0;
              end else begin
                pos_q <= p_sum[POS_W-1:0];
                vel_q <= v_new;
              end
            end
          end
        end
        S_CRASH: begin
          if (start) begin
            pos_q  <= PSTART;
            vel_q  <= '0;
            gcnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    state   = state_q;
    crashed = (state_q == S_CRASH);
    pos     = pos_q;
    vel     = vel_q;
    hit_top = hit_top_q;
  end

endmodule
